fifo_burst_reader: RTL
======================

// Module: fifo_burst_reader
// PURPOSE
//  Consumer side of fifo_sync_ram. Pops the FIFO's show-ahead read port and re-emits the words
//  as a registered valid/ready stream, grouped into fixed-length bursts with a last flag.
//  A burst starts once the FIFO reports half full. A fill that sits below half for TIMEOUT
//  cycles is drained as single-beat bursts. Sits between the pixel FIFO and downstream burst masters.
// PARAMETERS
//  WIDTH      32   data width; must equal the FIFO WIDTH
//  BURST_LEN  16   beats per full burst, >=2; the FIFO DEPTH is 2*BURST_LEN, so half => >=BURST_LEN words
//  TIMEOUT    255  cycles the FIFO is non-empty and below half before draining partial data, >=1
// PORTS
//  clk         in   1      clock
//  rest        in   1      asynchronous reset, active low
//  flush       in   1      synchronous abort: drop the output word, return to IDLE
//  fifo_empty  in   1      FIFO empty
//  fifo_half   in   1      FIFO count >= DEPTH/2
//  fifo_read   out  1      FIFO pop strobe, combinational
//  fifo_data   in   WIDTH  FIFO head word, valid whenever !fifo_empty
//  m_valid     out  1      output word valid (registered)
//  m_ready     in   1      downstream accepts
//  m_data      out  WIDTH  output word (registered)
//  m_last      out  1      final beat of a burst (registered)
//  busy        out  1      state != IDLE or m_valid
//  burst_cnt   out  16     completed bursts, counted on last-beat handshake, wraps at 2^16
// BEHAVIOUR
//  Reset (rest=0, async): state=IDLE; m_valid=0, m_data=0, m_last=0, burst_cnt=0, pop_cnt=0, idle_cnt=0
//   fifo_read=0 and busy=0 while in reset.
//  slot_free = !m_valid || m_ready.
//  fifo_read = !flush && !fifo_empty && slot_free &&
//   ((state==BURST && pop_cnt<BURST_LEN) || (state==SINGLE && pop_cnt==0)).
//  On fifo_read: m_data<=fifo_data, m_valid<=1, pop_cnt++.
//   m_last<=1 when (BURST && pop_cnt==BURST_LEN-1) or SINGLE; otherwise m_last<=0.
//  With m_valid && m_ready and no new pop: m_valid<=0.
//   While m_valid && !m_ready, m_data and m_last hold stable.
//  States
//   IDLE: pop_cnt=0.
//    idle_cnt: cleared when fifo_empty; else increments when !fifo_half; saturates at TIMEOUT.
//    fifo_half=1 -> BURST, idle_cnt<=0. Checked first.
//    else idle_cnt==TIMEOUT && !fifo_empty -> SINGLE.
//   BURST: handshake of a beat with m_last=1 -> IDLE, burst_cnt++.
//    If the FIFO empties mid-burst, the block stalls in BURST; no timeout applies.
//   SINGLE: handshake of the m_last beat -> IDLE, burst_cnt++.
//    idle_cnt stays saturated, so the next word drains at once unless half rises.
//  Latency: fifo_half high in cycle t (state IDLE) -> state BURST after edge t.
//   fifo_read=1 in cycle t+1; m_valid=1 in t+2. Full rate 1 beat/cycle with m_ready=1.
//  flush=1 (priority over all but reset): fifo_read=0 that cycle.
//   Next edge: m_valid=0, m_last=0, state=IDLE, pop_cnt=0, idle_cnt=0. burst_cnt unchanged.
//   Flush while m_valid=1 && m_ready=1 still counts that beat's handshake.
//  Never more than BURST_LEN pops per burst. Never pops when fifo_empty.
//  Async reset mid-burst aborts without any output handshake.
// TESTING
//  1 Reset: hold rest=0 with fifo_empty=0, fifo_half=1 -> fifo_read=0, m_valid=0, burst_cnt=0, busy=0.
//  2 FIFO holds 0..15, half=1, m_ready=1, BURST_LEN=16:
//    m_valid 2 cycles after half, 16 back-to-back beats 0..15, m_last on 15 only, burst_cnt=1.
//  3 As 2 with m_ready pattern 1,0,1,0...: order 0..15 kept, m_data stable while stalled,
//    exactly 16 pops, fifo_read=0 whenever m_valid&&!m_ready.
//  4 TIMEOUT=8, FIFO holds 3 words (A,B,C), half=0:
//    no output for 8 cycles, then three 1-beat bursts A,B,C each m_last=1, burst_cnt=3, back to IDLE.
//  5 flush after 5 accepted beats of a burst -> m_valid=0 next cycle, state IDLE,
//    burst_cnt unchanged, fifo_read=0 during the flush cycle. Next half restarts a 16-beat burst.
//  6 rest pulsed low mid-burst with m_valid=1 -> outputs zero immediately, burst_cnt=0, restart clean.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Pops a show-ahead FIFO into a registered valid/ready stream in BURST_LEN bursts, or single beats after TIMEOUT.
// Half-full -> first beat valid two cycles later, then 1 beat/cycle; a stalled output word holds and blocks pops.
module fifo_burst_reader #(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic             fifo_half,
  output logic             fifo_read,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic [15:0]      burst_cnt
);

  localparam int PW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] POP_LAST = PW'(BURST_LEN - 1);
  localparam logic [PW-1:0] POP_FULL = PW'(BURST_LEN);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BURST  = 2'd1;
  localparam logic [1:0] SINGLE = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] pop_cnt;
  logic [IW-1:0] idle_cnt;
  logic          slot_free;
  logic          handshake;

  assign slot_free = !m_valid || m_ready;
  assign handshake = m_valid && m_ready;
  assign busy      = (state != IDLE) || m_valid;

  assign fifo_read = !flush && !fifo_empty && slot_free &&
                     (((state == BURST) && (pop_cnt < POP_FULL)) ||
                      ((state == SINGLE) && (pop_cnt == '0)));

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state     <= IDLE;
      pop_cnt   <= '0;
      idle_cnt  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      // A last beat accepted in the same cycle as a flush still completes its burst.
      if (handshake && m_last) begin
        burst_cnt <= burst_cnt + 16'd1;
      end

      if (flush) begin
        m_valid  <= 1'b0;
        m_last   <= 1'b0;
        state    <= IDLE;
        pop_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        if (fifo_read) begin
          m_data  <= fifo_data;
          m_valid <= 1'b1;
          m_last  <= (state == SINGLE) || (pop_cnt == POP_LAST);
          pop_cnt <= pop_cnt + PW'(1);
        end else if (handshake) begin
          m_valid <= 1'b0;
        end

        case (state)
          IDLE: begin
            pop_cnt <= '0;
            if (fifo_half) begin
              state    <= BURST;
              idle_cnt <= '0;
            end else begin
              if ((idle_cnt == IDLE_MAX) && !fifo_empty) begin
                state <= SINGLE;
              end
              if (fifo_empty) begin
                idle_cnt <= '0;
              end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IW'(1);
              end
            end
          end
          // idle_cnt is left untouched here so a trickle keeps draining without re-waiting.
          BURST, SINGLE: begin
            if (handshake && m_last) begin
              state   <= IDLE;
              pop_cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
